// File: rtl/reorder_queue_mw_pkg.sv
// Shared types for the multi-wide reorder queue: entry layout, index type, class helpers.
// Entry field widths are fixed here; the top-level width parameters must keep these defaults.
package reorder_queue_mw_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_ADDR_W = 32;
  localparam int unsigned ROB_PREG_W = 6;
  localparam int unsigned ROB_MREG_W = 5;

  typedef logic [ROB_IDX_W-1:0] rob_index_t;

  typedef struct packed {
    logic                  want_write;
    logic                  is_store;
    logic                  is_branch;
    logic                  is_jump;
    logic                  is_jump_reg;
    logic                  prediction;
    logic [ROB_PREG_W-1:0] dst;
    logic [ROB_PREG_W-1:0] old;
    logic [ROB_MREG_W-1:0] mips;
    logic [ROB_ADDR_W-1:0] target;
    logic [ROB_ADDR_W-1:0] pc;
    logic [ROB_DATA_W-1:0] data;
    logic                  outcome;
  } rob_entry_t;

  // Any control-transfer entry ends a commit group and reports to the hazard controller.
  function automatic logic is_ctrl(input rob_entry_t e);
    return e.is_branch | e.is_jump | e.is_jump_reg;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Lane-enable chain: lane j retires only if lane j-1 did and no earlier lane was a branch or store.
module rob_commit_select #(
  parameter int unsigned COMMIT_W = 2,
  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] lane_occupied,
  input  logic [COMMIT_W-1:0] lane_ready,
  input  logic [COMMIT_W-1:0] lane_branch,
  input  logic [COMMIT_W-1:0] lane_store,
  output logic [COMMIT_W-1:0] valid_mask,
  output logic [CNT_W-1:0]    retire_cnt
);

  logic go;

  always_comb begin
    go         = 1'b1;
    valid_mask = '0;
    retire_cnt = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      valid_mask[j] = go && lane_occupied[j] && lane_ready[j];
      if (valid_mask[j]) retire_cnt = retire_cnt + CNT_W'(1);
      go = valid_mask[j] && !lane_branch[j] && !lane_store[j];
    end
  end

endmodule

// File: rtl/reorder_queue_mw.sv
// Multi-wide reorder queue: in-order allocate, out-of-order results on NUM_EXEC ports,
// up to COMMIT_W in-order retirements per cycle with zero-latency result bypass to commit.
module reorder_queue_mw
  import reorder_queue_mw_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned NUM_EXEC = 2,
  parameter int unsigned DATA_W   = ROB_DATA_W,
  parameter int unsigned ADDR_W   = ROB_ADDR_W,
  parameter int unsigned PREG_W   = ROB_PREG_W,
  parameter int unsigned MREG_W   = ROB_MREG_W,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_ins_valid,
  output logic                       o_ins_ready,
  input  logic                       i_ins_want_write,
  input  logic [PREG_W-1:0]          i_ins_dst,
  input  logic [PREG_W-1:0]          i_ins_old,
  input  logic [MREG_W-1:0]          i_ins_mips,
  input  logic                       i_ins_is_store,
  input  logic                       i_ins_is_branch,
  input  logic                       i_ins_is_jump,
  input  logic                       i_ins_is_jump_reg,
  input  logic                       i_ins_prediction,
  input  logic [ADDR_W-1:0]          i_ins_target,
  input  logic [ADDR_W-1:0]          i_ins_pc,
  output logic [IDX_W-1:0]           o_ins_index,
  input  logic [NUM_EXEC-1:0]        i_ex_valid,
  input  logic [NUM_EXEC*IDX_W-1:0]  i_ex_index,
  input  logic [NUM_EXEC*DATA_W-1:0] i_ex_data,
  input  logic [NUM_EXEC-1:0]        i_ex_outcome,
  output logic [COMMIT_W-1:0]        o_cm_valid,
  output logic [COMMIT_W-1:0]        o_cm_wb_valid,
  output logic [COMMIT_W*PREG_W-1:0] o_cm_dst,
  output logic [COMMIT_W*PREG_W-1:0] o_cm_old,
  output logic [COMMIT_W*MREG_W-1:0] o_cm_mips,
  output logic [COMMIT_W*DATA_W-1:0] o_cm_data,
  output logic [COMMIT_W-1:0]        o_cm_store,
  output logic [ADDR_W-1:0]          o_cm_pc,
  output logic                       o_br_valid,
  output logic                       o_br_prediction,
  output logic                       o_br_outcome,
  output logic [ADDR_W-1:0]          o_br_target,
  output logic [IDX_W:0]             o_count
);

  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];

  logic [IDX_W-1:0]  ex_index [NUM_EXEC];
  logic [DATA_W-1:0] ex_data  [NUM_EXEC];

  logic [IDX_W-1:0]    lane_idx [COMMIT_W];
  rob_entry_t          lane_ent [COMMIT_W];
  logic [COMMIT_W-1:0] lane_occ, lane_rdy, lane_br, lane_st;
  logic [COMMIT_W-1:0] cm_mask;
  logic [CNT_W-1:0]    retire_cnt;
  logic                ins_fire, live;
  rob_entry_t          ins_ent;

  assign o_ins_ready = (count_q != (IDX_W+1)'(DEPTH));
  assign o_ins_index = tail_q;
  assign o_count     = count_q;
  assign ins_fire    = i_ins_valid && o_ins_ready;
  assign live        = rst_n && !i_flush;

  always_comb begin
    for (int p = 0; p < NUM_EXEC; p++) begin
      ex_index[p] = i_ex_index[p*IDX_W +: IDX_W];
      ex_data[p]  = i_ex_data[p*DATA_W +: DATA_W];
    end
  end

  // Same-cycle port hits override the stored data/outcome so a result can retire immediately.
  always_comb begin
    for (int j = 0; j < COMMIT_W; j++) begin
      lane_idx[j] = head_q + IDX_W'(j);
      lane_ent[j] = ent_q[lane_idx[j]];
      lane_rdy[j] = ready_q[lane_idx[j]];
      for (int p = 0; p < NUM_EXEC; p++) begin
        if (i_ex_valid[p] && ex_index[p] == lane_idx[j]) begin
          lane_rdy[j]         = 1'b1;
          lane_ent[j].data    = ex_data[p];
          lane_ent[j].outcome = i_ex_outcome[p];
        end
      end
      lane_occ[j] = j < int'(count_q);
      lane_br[j]  = is_ctrl(lane_ent[j]);
      lane_st[j]  = lane_ent[j].is_store;
    end
  end

  rob_commit_select #(.COMMIT_W(COMMIT_W)) u_sel (
    .lane_occupied (lane_occ),
    .lane_ready    (lane_rdy),
    .lane_branch   (lane_br),
    .lane_store    (lane_st),
    .valid_mask    (cm_mask),
    .retire_cnt    (retire_cnt)
  );

  always_comb begin
    o_cm_valid      = '0;
    o_cm_wb_valid   = '0;
    o_cm_dst        = '0;
    o_cm_old        = '0;
    o_cm_mips       = '0;
    o_cm_data       = '0;
    o_cm_store      = '0;
    o_br_valid      = 1'b0;
    o_br_prediction = 1'b0;
    o_br_outcome    = 1'b0;
    o_br_target     = '0;
    o_cm_pc         = (live && count_q != '0) ? lane_ent[0].pc : '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (live && cm_mask[j]) begin
        o_cm_valid[j]                  = 1'b1;
        o_cm_wb_valid[j]               = lane_ent[j].want_write;
        o_cm_dst[j*PREG_W +: PREG_W]   = lane_ent[j].dst;
        o_cm_old[j*PREG_W +: PREG_W]   = lane_ent[j].old;
        o_cm_mips[j*MREG_W +: MREG_W]  = lane_ent[j].mips;
        o_cm_data[j*DATA_W +: DATA_W]  = lane_ent[j].data;
        o_cm_store[j]                  = lane_ent[j].is_store;
        if (lane_br[j]) begin
          o_br_valid      = 1'b1;
          o_br_prediction = lane_ent[j].prediction;
          o_br_outcome    = lane_ent[j].is_jump ? 1'b1 : lane_ent[j].outcome;
          o_br_target     = lane_ent[j].is_jump_reg ? lane_ent[j].data[ADDR_W-1:0]
                                                    : lane_ent[j].target;
        end
      end
    end
  end

  always_comb begin
    ins_ent             = '0;
    ins_ent.want_write  = i_ins_want_write;
    ins_ent.is_store    = i_ins_is_store;
    ins_ent.is_branch   = i_ins_is_branch;
    ins_ent.is_jump     = i_ins_is_jump;
    ins_ent.is_jump_reg = i_ins_is_jump_reg;
    ins_ent.prediction  = i_ins_prediction;
    ins_ent.dst         = i_ins_dst;
    ins_ent.old         = i_ins_old;
    ins_ent.mips        = i_ins_mips;
    ins_ent.target      = i_ins_target;
    ins_ent.pc          = i_ins_pc;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    ready_d = ready_q;
    ent_d   = ent_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      ready_d = '0;
    end else begin
      for (int p = 0; p < NUM_EXEC; p++) begin
        if (i_ex_valid[p] && valid_q[ex_index[p]]) begin
          ready_d[ex_index[p]]         = 1'b1;
          ent_d[ex_index[p]].data      = ex_data[p];
          ent_d[ex_index[p]].outcome   = i_ex_outcome[p];
        end
      end
      for (int j = 0; j < COMMIT_W; j++) begin
        if (cm_mask[j]) begin
          valid_d[lane_idx[j]] = 1'b0;
          ready_d[lane_idx[j]] = 1'b0;
        end
      end
      // Tail is never occupied when insert fires, so it cannot collide with a retiring lane.
      if (ins_fire) begin
        ent_d[tail_q]   = ins_ent;
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      head_d  = head_q + IDX_W'(retire_cnt);
      count_d = count_q + (IDX_W+1)'(ins_fire) - (IDX_W+1)'(retire_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !i_flush) begin
      for (int a = 0; a < NUM_EXEC; a++)
        for (int b = a + 1; b < NUM_EXEC; b++)
          assert (!(i_ex_valid[a] && i_ex_valid[b] && ex_index[a] == ex_index[b]));
    end
  end

endmodule

// File: tb/tb_reorder_queue_mw.sv
// Directed bench for reorder_queue_mw: wide commit, bypass, branch/store group limits, full, flush.
module tb_reorder_queue_mw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic        i_ins_valid;
  logic        o_ins_ready;
  logic        i_ins_want_write;
  logic [5:0]  i_ins_dst, i_ins_old;
  logic [4:0]  i_ins_mips;
  logic        i_ins_is_store, i_ins_is_branch, i_ins_is_jump, i_ins_is_jump_reg;
  logic        i_ins_prediction;
  logic [31:0] i_ins_target, i_ins_pc;
  logic [3:0]  o_ins_index;
  logic [1:0]  i_ex_valid;
  logic [7:0]  i_ex_index;
  logic [63:0] i_ex_data;
  logic [1:0]  i_ex_outcome;
  logic [1:0]  o_cm_valid, o_cm_wb_valid, o_cm_store;
  logic [11:0] o_cm_dst, o_cm_old;
  logic [9:0]  o_cm_mips;
  logic [63:0] o_cm_data;
  logic [31:0] o_cm_pc;
  logic        o_br_valid, o_br_prediction, o_br_outcome;
  logic [31:0] o_br_target;
  logic [4:0]  o_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reorder_queue_mw dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_ins_valid(i_ins_valid), .o_ins_ready(o_ins_ready),
    .i_ins_want_write(i_ins_want_write), .i_ins_dst(i_ins_dst), .i_ins_old(i_ins_old),
    .i_ins_mips(i_ins_mips), .i_ins_is_store(i_ins_is_store), .i_ins_is_branch(i_ins_is_branch),
    .i_ins_is_jump(i_ins_is_jump), .i_ins_is_jump_reg(i_ins_is_jump_reg),
    .i_ins_prediction(i_ins_prediction), .i_ins_target(i_ins_target), .i_ins_pc(i_ins_pc),
    .o_ins_index(o_ins_index),
    .i_ex_valid(i_ex_valid), .i_ex_index(i_ex_index), .i_ex_data(i_ex_data),
    .i_ex_outcome(i_ex_outcome),
    .o_cm_valid(o_cm_valid), .o_cm_wb_valid(o_cm_wb_valid), .o_cm_dst(o_cm_dst),
    .o_cm_old(o_cm_old), .o_cm_mips(o_cm_mips), .o_cm_data(o_cm_data), .o_cm_store(o_cm_store),
    .o_cm_pc(o_cm_pc), .o_br_valid(o_br_valid), .o_br_prediction(o_br_prediction),
    .o_br_outcome(o_br_outcome), .o_br_target(o_br_target), .o_count(o_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    i_ex_valid   = '0;
    i_ex_index   = '0;
    i_ex_data    = '0;
    i_ex_outcome = '0;
  endtask

  // One-cycle insert; checks the allocated index just before the edge.
  task automatic ins_one(input logic [5:0] dst, input logic ww, input logic st, input logic br,
                         input logic jp, input logic jr, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] pc, input logic [3:0] exp_idx);
    i_ins_valid       = 1'b1;
    i_ins_want_write  = ww;
    i_ins_dst         = dst;
    i_ins_old         = dst + 6'd20;
    i_ins_mips        = dst[4:0];
    i_ins_is_store    = st;
    i_ins_is_branch   = br;
    i_ins_is_jump     = jp;
    i_ins_is_jump_reg = jr;
    i_ins_prediction  = pred;
    i_ins_target      = tgt;
    i_ins_pc          = pc;
    @(negedge clk);
    chk("ins_index", o_ins_index, exp_idx);
    tick();
    i_ins_valid = 1'b0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_cm_valid", o_cm_valid, 2'b00);
    chk("flush_br_valid", o_br_valid, 1'b0);
    chk("flush_pc", o_cm_pc, 32'h0);
    tick();
    i_flush = 1'b0;
    chk("flush_count", o_count, 5'd0);
    chk("flush_tail", o_ins_index, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_ins_valid = 1'b0; i_ins_want_write = 1'b0;
    i_ins_dst = '0; i_ins_old = '0; i_ins_mips = '0; i_ins_is_store = 1'b0;
    i_ins_is_branch = 1'b0; i_ins_is_jump = 1'b0; i_ins_is_jump_reg = 1'b0;
    i_ins_prediction = 1'b0; i_ins_target = '0; i_ins_pc = '0;
    clr_ex();
    tick();
    tick();
    @(negedge clk);
    chk("rst_cm_valid", o_cm_valid, 2'b00);
    chk("rst_count", o_count, 5'd0);
    chk("rst_br_valid", o_br_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_ins_ready", o_ins_ready, 1'b1);

    // Three ALU ops; two results in one cycle retire as a pair.
    ins_one(6'd10, 1, 0, 0, 0, 0, 0, 32'h0, 32'h100, 4'd0);
    ins_one(6'd11, 1, 0, 0, 0, 0, 0, 32'h0, 32'h104, 4'd1);
    ins_one(6'd12, 1, 0, 0, 0, 0, 0, 32'h0, 32'h108, 4'd2);
    chk("t1_count3", o_count, 5'd3);
    chk("t1_not_ready", o_cm_valid, 2'b00);
    chk("t1_pc_head", o_cm_pc, 32'h100);
    i_ex_valid = 2'b11; i_ex_index = {4'd1, 4'd0}; i_ex_data = {32'hA1, 32'hA0};
    @(negedge clk);
    chk("t1_a_valid", o_cm_valid, 2'b11);
    chk("t1_a_wb", o_cm_wb_valid, 2'b11);
    chk("t1_a_dst", o_cm_dst, {6'd11, 6'd10});
    chk("t1_a_data", o_cm_data, {32'hA1, 32'hA0});
    chk("t1_a_mips", o_cm_mips, {5'd11, 5'd10});
    tick();
    clr_ex();
    chk("t1_count1", o_count, 5'd1);
    chk("t1_idle", o_cm_valid, 2'b00);
    i_ex_valid = 2'b01; i_ex_index = {4'd0, 4'd2}; i_ex_data = {32'h0, 32'hA2};
    @(negedge clk);
    chk("t1_b_valid", o_cm_valid, 2'b01);
    chk("t1_b_dst", o_cm_dst[5:0], 6'd12);
    chk("t1_b_old", o_cm_old[5:0], 6'd32);
    tick();
    clr_ex();
    chk("t1_count0", o_count, 5'd0);

    // Fill to DEPTH from index 0; extra insert is ignored; tail wraps to 0.
    do_flush();
    for (int k = 0; k < 16; k++)
      ins_one(6'(k + 1), 1, 0, 0, 0, 0, 0, 32'h0, 32'h1000 + 32'(4 * k), 4'(k));
    chk("t2_full_count", o_count, 5'd16);
    chk("t2_full_ready", o_ins_ready, 1'b0);
    chk("t2_tail_wrap", o_ins_index, 4'd0);
    i_ins_valid = 1'b1; i_ins_dst = 6'd63;
    tick();
    i_ins_valid = 1'b0;
    chk("t2_extra_ignored", o_count, 5'd16);
    i_ex_valid = 2'b11; i_ex_index = {4'd1, 4'd0}; i_ex_data = {32'hB1, 32'hB0};
    @(negedge clk);
    chk("t2_pc_head", o_cm_pc, 32'h1000);
    chk("t2_ret_valid", o_cm_valid, 2'b11);
    chk("t2_ret_dst", o_cm_dst, {6'd2, 6'd1});
    chk("t2_ready_registered", o_ins_ready, 1'b0);
    tick();
    clr_ex();
    chk("t2_count14", o_count, 5'd14);
    chk("t2_ready_again", o_ins_ready, 1'b1);
    ins_one(6'd40, 1, 0, 0, 0, 0, 0, 32'h0, 32'h2000, 4'd0);
    chk("t2_count15", o_count, 5'd15);

    // Branch at head ends the group even though the next entry is ready.
    do_flush();
    ins_one(6'd0, 0, 0, 1, 0, 0, 0, 32'h2000, 32'h3000, 4'd0);
    ins_one(6'd5, 1, 0, 0, 0, 0, 0, 32'h0, 32'h3004, 4'd1);
    i_ex_valid = 2'b11; i_ex_index = {4'd1, 4'd0}; i_ex_data = {32'h55, 32'h0};
    i_ex_outcome = 2'b01;
    @(negedge clk);
    chk("t3_valid", o_cm_valid, 2'b01);
    chk("t3_wb", o_cm_wb_valid, 2'b00);
    chk("t3_br_valid", o_br_valid, 1'b1);
    chk("t3_br_outcome", o_br_outcome, 1'b1);
    chk("t3_br_pred", o_br_prediction, 1'b0);
    chk("t3_br_target", o_br_target, 32'h2000);
    tick();
    clr_ex();
    @(negedge clk);
    chk("t3_next_valid", o_cm_valid, 2'b01);
    chk("t3_next_dst", o_cm_dst[5:0], 6'd5);
    chk("t3_next_data", o_cm_data[31:0], 32'h55);
    chk("t3_next_br", o_br_valid, 1'b0);
    tick();
    chk("t3_count0", o_count, 5'd0);

    // jump_reg target comes from the bypassed result; plain jump forces taken.
    ins_one(6'd0, 0, 0, 0, 0, 1, 1, 32'hDEAD, 32'h3008, 4'd2);
    i_ex_valid = 2'b10; i_ex_index = {4'd2, 4'd0}; i_ex_data = {32'h0040_0100, 32'h0};
    i_ex_outcome = 2'b10;
    @(negedge clk);
    chk("t4_jr_valid", o_cm_valid, 2'b01);
    chk("t4_jr_br", o_br_valid, 1'b1);
    chk("t4_jr_target", o_br_target, 32'h0040_0100);
    chk("t4_jr_outcome", o_br_outcome, 1'b1);
    tick();
    clr_ex();
    chk("t4_count0", o_count, 5'd0);
    ins_one(6'd0, 0, 0, 0, 1, 0, 1, 32'h4444, 32'h300C, 4'd3);
    i_ex_valid = 2'b01; i_ex_index = {4'd0, 4'd3}; i_ex_data = {32'h0, 32'h99};
    i_ex_outcome = 2'b00;
    @(negedge clk);
    chk("t4_j_outcome", o_br_outcome, 1'b1);
    chk("t4_j_target", o_br_target, 32'h4444);
    tick();
    clr_ex();

    // Two ready stores retire one per cycle.
    ins_one(6'd0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h3010, 4'd4);
    ins_one(6'd0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h3014, 4'd5);
    i_ex_valid = 2'b11; i_ex_index = {4'd5, 4'd4}; i_ex_data = '0;
    @(negedge clk);
    chk("t5_st1_valid", o_cm_valid, 2'b01);
    chk("t5_st1_store", o_cm_store, 2'b01);
    tick();
    clr_ex();
    @(negedge clk);
    chk("t5_st2_valid", o_cm_valid, 2'b01);
    chk("t5_st2_store", o_cm_store, 2'b01);
    chk("t5_st2_pc", o_cm_pc, 32'h3014);
    tick();
    chk("t5_count0", o_count, 5'd0);

    // Out-of-order result does not commit past an unready head; flush wins over a head result.
    do_flush();
    for (int k = 0; k < 4; k++)
      ins_one(6'(k + 20), 1, 0, 0, 0, 0, 0, 32'h0, 32'h5000 + 32'(4 * k), 4'(k));
    i_ex_valid = 2'b01; i_ex_index = {4'd0, 4'd3}; i_ex_data = {32'h0, 32'h33};
    @(negedge clk);
    chk("t6_ooo_none", o_cm_valid, 2'b00);
    tick();
    clr_ex();
    chk("t6_count4", o_count, 5'd4);
    i_ex_valid = 2'b01; i_ex_index = {4'd0, 4'd0}; i_ex_data = {32'h0, 32'h44};
    do_flush();
    clr_ex();
    chk("t6_post_flush_idle", o_cm_valid, 2'b00);
    ins_one(6'd7, 1, 0, 0, 0, 0, 0, 32'h0, 32'h6000, 4'd0);
    i_ex_valid = 2'b10; i_ex_index = {4'd0, 4'd0}; i_ex_data = {32'h77, 32'h0};
    @(negedge clk);
    chk("t6_restart_valid", o_cm_valid, 2'b01);
    chk("t6_restart_data", o_cm_data[31:0], 32'h77);
    tick();
    clr_ex();
    chk("t6_count0", o_count, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
